apb4_slave_mem: RTL



---
 rtl/apb4_slave_mem.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/apb4_slave_mem.sv
// APB4 completer: word-addressed register memory with byte strobes, runtime wait
// states, PSLVERR signalling and a saturating error counter.
module apb4_slave_mem #(
    parameter int unsigned                APB_BUS_W  = 32,
    parameter int unsigned                APB_ADDR_W = 32,
    parameter int unsigned                MEM_DEPTH  = 64,
    parameter logic [APB_ADDR_W-1:0]      BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [APB_ADDR_W-1:0]   paddr,
    input  logic [APB_BUS_W-1:0]    pwdata,
    input  logic [APB_BUS_W/8-1:0]  pstrb,
    input  logic [2:0]              pprot,
    input  logic [3:0]              wait_cfg,
    output logic                    pready,
    output logic [APB_BUS_W-1:0]    prdata,
    output logic                    pslverr,
    output logic [15:0]             err_cnt
);

    localparam int unsigned BYTES = APB_BUS_W / 8;
    localparam int unsigned ALIGN = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [APB_ADDR_W-1:0] SPAN       = APB_ADDR_W'(MEM_DEPTH * BYTES);
    localparam logic [APB_ADDR_W-1:0] ALIGN_MASK = APB_ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d, phase;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;
    logic                   wr_q, wr_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic                   pready_q, pready_d;
    logic [APB_BUS_W-1:0]   prdata_q, prdata_d;
    logic                   pslverr_q, pslverr_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic                   mem_we;

    logic [APB_ADDR_W-1:0]  off;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_err;
    logic                   unused_prot;

    logic [APB_BUS_W-1:0]   mem [MEM_DEPTH];

    assign unused_prot = ^pprot[2:1];

    // Underflow of paddr below BASE_ADDR wraps to a huge offset and fails the range test.
    always_comb begin
        off     = paddr - BASE_ADDR;
        dec_idx = off[ALIGN +: IDX_W];
        dec_err = (off >= SPAN)
                | ((paddr & ALIGN_MASK) != '0)
                | (!pwrite && (pstrb != '0))
                | (pwrite && (dec_idx == '0) && !pprot[0]);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        wr_d      = wr_q;
        wcnt_d    = wcnt_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;

        // The setup cycle is recognised from the live bus so that a zero-wait
        // transfer can present its registered response in the first access cycle.
        phase = state_q;
        if (state_q != ACCESS && psel && !penable) begin
            phase = SETUP;
        end

        case (phase)
            SETUP: begin
                state_d = ACCESS;
                idx_d   = dec_idx;
                err_d   = dec_err;
                wr_d    = pwrite;
                wcnt_d  = wait_cfg;
                if (wait_cfg == '0) begin
                    pready_d  = 1'b1;
                    pslverr_d = dec_err;
                    if (!pwrite && !dec_err) begin
                        prdata_d = mem[dec_idx];
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (pready_q) begin
                    state_d = IDLE;
                    if (penable) begin
                        mem_we = wr_q && !err_q;
                        if (err_q && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!wr_q && !err_q) begin
                            prdata_d = mem[idx_q];
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            wcnt_q    <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            wcnt_q    <= wcnt_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (pstrb[k]) begin
                    mem[idx_q][k*8 +: 8] <= pwdata[k*8 +: 8];
                end
            end
        end
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;
    assign err_cnt = err_cnt_q;

endmodule
